// File: rtl/output_arbiter.sv
// output_arbiter: two-input round-robin arbiter that issues one selector
// token per pending packet to the output merge stage over valid/ready.
// Optional build macro OUTARB_STATS_EN enables the 16-bit per-input
// accepted-grant counters; without it gcnt0_o/gcnt1_o are tied to zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no token offered, waiting for a nonzero pending count
// S_OFFER | sel_valid_o=1, sel_o held until the merge stage accepts it
module output_arbiter #(
   parameter int CNT_W    = 4,
   parameter bit SEL_PRI0 = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_i,
   input  logic             req1_i,
   output logic             sel_valid_o,
   input  logic             sel_ready_i,
   output logic             sel_o,
   output logic [CNT_W-1:0] pend0_o,
   output logic [CNT_W-1:0] pend1_o,
   output logic             ovf0_o,
   output logic             ovf1_o,
   output logic [15:0]      gcnt0_o,
   output logic [15:0]      gcnt1_o
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_pend0;
   logic [CNT_W-1:0] r_pend1;
   logic [CNT_W-1:0] w_pend0_nxt;
   logic [CNT_W-1:0] w_pend1_nxt;
   logic             r_ovf0;
   logic             r_ovf1;
   logic             w_ovf0_nxt;
   logic             w_ovf1_nxt;
   logic             r_sel;
   logic             w_sel_nxt;
   // last_grant: input granted at the most recent selection
   logic             r_last;
   logic             w_last_nxt;
   logic             w_hs;
   logic             w_any;
   logic             w_pick;
   logic             w_take;
   logic             w_dec0;
   logic             w_dec1;

   // Selection decision and FSM next state, using only registered counts
   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_last_nxt  = r_last;
      w_hs        = (r_state == S_OFFER) & sel_ready_i;
      w_any       = (r_pend0 != '0) | (r_pend1 != '0);
      if ((r_pend0 != '0) && (r_pend1 != '0)) begin
         w_pick = ~r_last;
      end else begin
         w_pick = (r_pend0 == '0);
      end
      w_take = w_any & ((r_state == S_IDLE) | w_hs);
      w_dec0 = w_take & ~w_pick;
      w_dec1 = w_take & w_pick;
      if (w_take) begin
         w_sel_nxt  = w_pick;
         w_last_nxt = w_pick;
      end
      case (r_state)
         S_IDLE: begin
            if (w_take) begin
               w_state_nxt = S_OFFER;
            end
         end
         S_OFFER: begin
            if (w_hs && !w_take) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Pending counters: +req, -selection, saturate and flag a dropped request
   always_comb begin
      w_pend0_nxt = r_pend0;
      w_ovf0_nxt  = r_ovf0;
      if (req0_i && !w_dec0) begin
         if (r_pend0 == PEND_MAX) begin
            w_ovf0_nxt = 1'b1;
         end else begin
            w_pend0_nxt = r_pend0 + PEND_ONE;
         end
      end else if (!req0_i && w_dec0) begin
         w_pend0_nxt = r_pend0 - PEND_ONE;
      end

      w_pend1_nxt = r_pend1;
      w_ovf1_nxt  = r_ovf1;
      if (req1_i && !w_dec1) begin
         if (r_pend1 == PEND_MAX) begin
            w_ovf1_nxt = 1'b1;
         end else begin
            w_pend1_nxt = r_pend1 + PEND_ONE;
         end
      end else if (!req1_i && w_dec1) begin
         w_pend1_nxt = r_pend1 - PEND_ONE;
      end
   end

   // State, selector and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sel   <= 1'b0;
         r_last  <= SEL_PRI0;
         r_pend0 <= '0;
         r_pend1 <= '0;
         r_ovf0  <= 1'b0;
         r_ovf1  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_last  <= w_last_nxt;
         r_pend0 <= w_pend0_nxt;
         r_pend1 <= w_pend1_nxt;
         r_ovf0  <= w_ovf0_nxt;
         r_ovf1  <= w_ovf1_nxt;
      end
   end

   assign sel_valid_o = (r_state == S_OFFER);
   assign sel_o       = r_sel;
   assign pend0_o     = r_pend0;
   assign pend1_o     = r_pend1;
   assign ovf0_o      = r_ovf0;
   assign ovf1_o      = r_ovf1;

`ifdef OUTARB_STATS_EN
   logic [15:0] r_gcnt0;
   logic [15:0] r_gcnt1;

   // Accepted-grant counters, wrapping modulo 2^16
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gcnt0 <= '0;
         r_gcnt1 <= '0;
      end else if (w_hs) begin
         if (r_sel) begin
            r_gcnt1 <= r_gcnt1 + 16'd1;
         end else begin
            r_gcnt0 <= r_gcnt0 + 16'd1;
         end
      end
   end

   assign gcnt0_o = r_gcnt0;
   assign gcnt1_o = r_gcnt1;
`else
   assign gcnt0_o = '0;
   assign gcnt1_o = '0;
`endif

endmodule
